// File: rtl/uart_command_parser.sv
// uart_command_parser: turns framed host commands arriving from uart_rx into
// token/weight BRAM word writes and a matmul start pulse. Frames that stall
// between bytes for longer than TIMEOUT_CYCLES are aborted.
module uart_command_parser #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  layer_busy,
  output logic                  token_wr_en,
  output logic [ADDR_WIDTH-1:0] token_wr_addr,
  output logic [DATA_WIDTH-1:0] token_wr_data,
  output logic                  weight_wr_en,
  output logic [ADDR_WIDTH-1:0] weight_wr_addr,
  output logic [DATA_WIDTH-1:0] weight_wr_data,
  output logic                  start_matmul,
  output logic                  frame_active,
  output logic                  frame_error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] OP_TOKEN  = 8'hA1;
  localparam logic [7:0] OP_WEIGHT = 8'hA2;
  localparam logic [7:0] OP_START  = 8'hA3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA
  } state_t;

  state_t                r_state;
  logic                  r_is_weight;
  logic [7:0]            r_addr_hi;
  logic [7:0]            r_cnt_hi;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_remaining;
  logic [BCW-1:0]        r_byte_cnt;
  logic [DATA_WIDTH-1:0] r_word;
  logic [TW-1:0]         r_timeout;

  // Word assembled from the bytes received so far plus the one arriving now (MSB first).
  logic [DATA_WIDTH-1:0] w_word_next;
  assign w_word_next = (r_word << 8) | DATA_WIDTH'(rx_data);

  // Frame FSM, timeout counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_is_weight    <= 1'b0;
      r_addr_hi      <= '0;
      r_cnt_hi       <= '0;
      r_addr         <= '0;
      r_remaining    <= '0;
      r_byte_cnt     <= '0;
      r_word         <= '0;
      r_timeout      <= '0;
      token_wr_en    <= 1'b0;
      token_wr_addr  <= '0;
      token_wr_data  <= '0;
      weight_wr_en   <= 1'b0;
      weight_wr_addr <= '0;
      weight_wr_data <= '0;
      start_matmul   <= 1'b0;
      frame_active   <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      token_wr_en  <= 1'b0;
      weight_wr_en <= 1'b0;
      start_matmul <= 1'b0;
      frame_error  <= 1'b0;

      if (r_state == S_IDLE || rx_valid) r_timeout <= '0;
      else                               r_timeout <= r_timeout + TW'(1);

      if (r_state != S_IDLE && !rx_valid && r_timeout == TW'(TIMEOUT_CYCLES - 1)) begin
        // Stalled frame: drop any partial word, keep words already written.
        r_state      <= S_IDLE;
        frame_active <= 1'b0;
        frame_error  <= 1'b1;
      end else if (rx_valid) begin
        case (r_state)
          S_IDLE: begin
            if (rx_data == OP_TOKEN || rx_data == OP_WEIGHT) begin
              r_is_weight  <= (rx_data == OP_WEIGHT);
              r_state      <= S_ADDR_HI;
              frame_active <= 1'b1;
            end else if (rx_data == OP_START) begin
              if (layer_busy) frame_error  <= 1'b1;
              else            start_matmul <= 1'b1;
            end
          end
          S_ADDR_HI: begin
            r_addr_hi <= rx_data;
            r_state   <= S_ADDR_LO;
          end
          S_ADDR_LO: begin
            r_addr  <= ADDR_WIDTH'({r_addr_hi, rx_data});
            r_state <= S_CNT_HI;
          end
          S_CNT_HI: begin
            r_cnt_hi <= rx_data;
            r_state  <= S_CNT_LO;
          end
          S_CNT_LO: begin
            r_remaining <= {r_cnt_hi, rx_data};
            r_byte_cnt  <= '0;
            r_word      <= '0;
            if ({r_cnt_hi, rx_data} == 16'd0) begin
              r_state      <= S_IDLE;
              frame_active <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            if (r_byte_cnt == BCW'(BYTES - 1)) begin
              r_byte_cnt <= '0;
              r_word     <= '0;
              if (r_is_weight) begin
                weight_wr_en   <= 1'b1;
                weight_wr_addr <= r_addr;
                weight_wr_data <= w_word_next;
              end else begin
                token_wr_en    <= 1'b1;
                token_wr_addr  <= r_addr;
                token_wr_data  <= w_word_next;
              end
              r_addr      <= r_addr + ADDR_WIDTH'(1);
              r_remaining <= r_remaining - 16'd1;
              if (r_remaining == 16'd1) begin
                r_state      <= S_IDLE;
                frame_active <= 1'b0;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + BCW'(1);
              r_word     <= w_word_next;
            end
          end
          default: begin
            r_state      <= S_IDLE;
            frame_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_command_parser.sv
// Directed bench for uart_command_parser with a short timeout.
module tb_uart_command_parser;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          layer_busy;
  logic          token_wr_en, weight_wr_en;
  logic [AW-1:0] token_wr_addr, weight_wr_addr;
  logic [DW-1:0] token_wr_data, weight_wr_data;
  logic          start_matmul, frame_active, frame_error;

  int n_checks = 0;
  int n_pass   = 0;

  // Write log captured away from the active edge.
  logic [AW-1:0] tok_addr_q[$];
  logic [DW-1:0] tok_data_q[$];
  logic [AW-1:0] wt_addr_q[$];
  logic [DW-1:0] wt_data_q[$];
  logic          wt_fa_q[$];
  int            start_cycles = 0;
  int            error_cycles = 0;

  uart_command_parser #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .layer_busy(layer_busy),
    .token_wr_en(token_wr_en), .token_wr_addr(token_wr_addr), .token_wr_data(token_wr_data),
    .weight_wr_en(weight_wr_en), .weight_wr_addr(weight_wr_addr), .weight_wr_data(weight_wr_data),
    .start_matmul(start_matmul), .frame_active(frame_active), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (token_wr_en) begin
      tok_addr_q.push_back(token_wr_addr);
      tok_data_q.push_back(token_wr_data);
    end
    if (weight_wr_en) begin
      wt_addr_q.push_back(weight_wr_addr);
      wt_data_q.push_back(weight_wr_data);
      wt_fa_q.push_back(frame_active);
    end
    if (start_matmul) start_cycles++;
    if (frame_error)  error_cycles++;
  end

  task automatic clear_log();
    @(negedge clk);
    tok_addr_q.delete(); tok_data_q.delete();
    wt_addr_q.delete();  wt_data_q.delete(); wt_fa_q.delete();
    start_cycles = 0;
    error_cycles = 0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({token_wr_en, token_wr_addr, token_wr_data, weight_wr_en, weight_wr_addr,
         weight_wr_data, start_matmul, frame_active, frame_error} !== '0)
      $display("FAIL reset_outputs: got tok=%b/%h/%h wt=%b/%h/%h st=%b fa=%b fe=%b, want all 0",
               token_wr_en, token_wr_addr, token_wr_data, weight_wr_en, weight_wr_addr,
               weight_wr_data, start_matmul, frame_active, frame_error);
    else n_pass++;
  endtask

  task automatic test_token_write();
    clear_log();
    send(8'hA1); send(8'h00); send(8'h05); send(8'h00); send(8'h02);
    send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
    idle(4);
    n_checks++;
    if (tok_addr_q.size() != 2) $display("FAIL tok_count: got %0d want 2", tok_addr_q.size());
    else begin
      n_pass++;
      n_checks++;
      if (tok_addr_q[0] !== 10'h005 || tok_data_q[0] !== 16'h1234)
        $display("FAIL tok_word0: got %h/%h want 005/1234", tok_addr_q[0], tok_data_q[0]);
      else n_pass++;
      n_checks++;
      if (tok_addr_q[1] !== 10'h006 || tok_data_q[1] !== 16'hABCD)
        $display("FAIL tok_word1: got %h/%h want 006/abcd", tok_addr_q[1], tok_data_q[1]);
      else n_pass++;
    end
    n_checks++;
    if (wt_addr_q.size() != 0) $display("FAIL tok_no_weight: got %0d weight writes want 0", wt_addr_q.size());
    else n_pass++;
    n_checks++;
    if (frame_active !== 1'b0) $display("FAIL tok_frame_active: got %b want 0", frame_active);
    else n_pass++;
  endtask

  task automatic test_weight_wrap();
    logic [AW-1:0] ea[3] = '{10'h3FF, 10'h000, 10'h001};
    logic [DW-1:0] ed[3] = '{16'h0102, 16'h0304, 16'h0506};
    logic          ef[3] = '{1'b1, 1'b1, 1'b0};
    clear_log();
    send(8'hA2); send(8'h03); send(8'hFF); send(8'h00); send(8'h03);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05); send(8'h06);
    idle(4);
    n_checks++;
    if (wt_addr_q.size() != 3) $display("FAIL wt_count: got %0d want 3", wt_addr_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (wt_addr_q[i] !== ea[i] || wt_data_q[i] !== ed[i] || wt_fa_q[i] !== ef[i])
          $display("FAIL wt_word%0d: got %h/%h fa=%b want %h/%h fa=%b",
                   i, wt_addr_q[i], wt_data_q[i], wt_fa_q[i], ea[i], ed[i], ef[i]);
        else n_pass++;
      end
    end
    n_checks++;
    if (tok_addr_q.size() != 0) $display("FAIL wt_no_token: got %0d want 0", tok_addr_q.size());
    else n_pass++;
  endtask

  task automatic test_start();
    clear_log();
    layer_busy = 1'b0;
    send(8'hA3);
    idle(4);
    n_checks++;
    if (start_cycles != 1 || error_cycles != 0)
      $display("FAIL start_idle: got start=%0d err=%0d want 1/0", start_cycles, error_cycles);
    else n_pass++;
    clear_log();
    layer_busy = 1'b1;
    send(8'hA3);
    idle(4);
    layer_busy = 1'b0;
    n_checks++;
    if (start_cycles != 0 || error_cycles != 1)
      $display("FAIL start_busy: got start=%0d err=%0d want 0/1", start_cycles, error_cycles);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int  waited = 0;
    bit  seen   = 0;
    clear_log();
    send(8'hA1); send(8'h00); send(8'h10); send(8'h00); send(8'h02);
    send(8'h11); send(8'h22); send(8'h33);
    while (!seen && waited < TO + 20) begin
      idle(1);
      waited++;
      if (frame_error) seen = 1;
    end
    n_checks++;
    if (!seen || waited < TO || waited > TO + 2)
      $display("FAIL timeout_pulse: seen=%0d after %0d idle cycles want seen=1 within %0d..%0d",
               seen, waited, TO, TO + 2);
    else n_pass++;
    idle(3);
    n_checks++;
    if (error_cycles != 1 || frame_active !== 1'b0)
      $display("FAIL timeout_abort: got err=%0d fa=%b want 1/0", error_cycles, frame_active);
    else n_pass++;
    n_checks++;
    if (tok_addr_q.size() != 1 || tok_addr_q[0] !== 10'h010 || tok_data_q[0] !== 16'h1122)
      $display("FAIL timeout_writes: got %0d writes want one 010/1122", tok_addr_q.size());
    else n_pass++;
    send(8'hA3);
    idle(3);
    n_checks++;
    if (start_cycles != 1) $display("FAIL timeout_then_start: got %0d want 1", start_cycles);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_log();
    send(8'hA1); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    send(8'h55);
    idle(1);
    n_checks++;
    if (frame_active !== 1'b0) $display("FAIL zero_cnt_idle: got fa=%b want 0", frame_active);
    else n_pass++;
    send(8'hA3);
    idle(3);
    n_checks++;
    if (tok_addr_q.size() != 0 || wt_addr_q.size() != 0 || start_cycles != 1 || error_cycles != 0)
      $display("FAIL zero_cnt_start: got tok=%0d wt=%0d st=%0d err=%0d want 0/0/1/0",
               tok_addr_q.size(), wt_addr_q.size(), start_cycles, error_cycles);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    clear_log();
    send(8'hA2); send(8'h00); send(8'h01); send(8'h00); send(8'h01); send(8'hAA);
    @(negedge clk);
    rx_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    test_reset();
    idle(2);
    rst = 1'b0;
    idle(3);
    n_checks++;
    if (wt_addr_q.size() != 0) $display("FAIL rst_no_write: got %0d writes want 0", wt_addr_q.size());
    else n_pass++;
    send(8'hA2); send(8'h00); send(8'h01); send(8'h00); send(8'h01); send(8'hAA); send(8'hBB);
    idle(3);
    n_checks++;
    if (wt_addr_q.size() != 1 || wt_addr_q[0] !== 10'h001 || wt_data_q[0] !== 16'hAABB)
      $display("FAIL rst_resend: got %0d writes want one 001/aabb", wt_addr_q.size());
    else n_pass++;
  endtask

  initial begin
    rst        = 1'b1;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    layer_busy = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    idle(2);
    test_token_write();
    test_weight_wrap();
    test_start();
    test_timeout();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
